bcd_addsub_seq: RTL

- Parametrised digit-serial BCD adder/subtractor for DIGITS packed BCD digits. Result is (a ± b) mod 10^DIGITS, plus a decimal carry/borrow flag.
- Processes one digit per clock, least significant digit first, through a single shared combinational digit cell.
- Valid/ready handshake on input and output, so it can sit between a BCD operand source and a display/result consumer.
- Adds non-BCD input detection, which the earlier combinational 2-digit unit lacks.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_addsub.sv | 43 ++++
 rtl/bcd_addsub_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and helpers for the digit-serial arithmetic units.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_e;

    // True when the nibble is a legal decimal digit (0..9).
    function automatic logic is_bcd(input bcd_digit_t digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// One-digit decimal add/subtract cell with carry/borrow in and out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller sequences digits.
module bcd_digit_addsub
    import bcd_pkg::*;
(
    input  bcd_digit_t x,
    input  bcd_digit_t y,
    input  logic       c_in,
    input  logic       sub,
    output bcd_digit_t s,
    output logic       c_out
);

    // Five bits cover 15+15+1 on the add side and 0-15-1 (bit 4 as sign) on the subtract side,
    // so non-BCD inputs still produce a defined, if meaningless, value.
    logic [4:0] t_add;
    logic [4:0] t_sub;

    // Decimal correction: wrap sums above 9 and negative differences back into 0..9.
    always_comb begin
        t_add = 5'(x) + 5'(y) + 5'(c_in);
        t_sub = 5'(x) - 5'(y) - 5'(c_in);
        s     = '0;
        c_out = 1'b0;
        if (!sub) begin
            if (t_add > 5'd9) begin
                s     = 4'(t_add - 5'd10);
                c_out = 1'b1;
            end else begin
                s     = t_add[3:0];
            end
        end else begin
            if (t_sub[4]) begin
                s     = 4'(t_sub + 5'd10);
                c_out = 1'b1;
            end else begin
                s     = t_sub[3:0];
            end
        end
    end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Digit-serial BCD adder/subtractor, LSD first, one digit per clock through a shared cell.
// Latency: result valid DIGITS+1 cycles after the accept cycle; accepts spaced >= DIGITS+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready low whenever an operation is in flight.
module bcd_addsub_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    fsm_e          state;
    fsm_e          state_nxt;

    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  res_sr;
    logic [W-1:0]  res_nxt;
    logic          sub_q;
    logic          carry_q;
    logic [CW-1:0] cnt;
    logic          last_digit;
    logic          in_bad;

    logic [W-1:0]  result_q;
    logic          cout_q;
    logic          err_q;

    bcd_digit_t    cell_s;
    logic          cell_c;

    // The operand shift registers always present the current digit in their low nibble.
    bcd_digit_addsub u_cell (
        .x     (a_sr[3:0]),
        .y     (b_sr[3:0]),
        .c_in  (carry_q),
        .sub   (sub_q),
        .s     (cell_s),
        .c_out (cell_c)
    );

    assign last_digit = (cnt == CW'(DIGITS - 1));

    // New digit enters at the top so after DIGITS shifts the LSD sits at bit 0.
    assign res_nxt = (res_sr >> 4) | (W'(cell_s) << (W - 4));

    // Flag any nibble of either operand outside 0..9 at capture time.
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(a[4*i +: 4]) || !is_bcd(b[4*i +: 4])) begin
                in_bad = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last_digit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, per-digit shifting and final result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        sub_q   <= sub;
                        carry_q <= 1'b0;
                        err_q   <= in_bad;
                        cnt     <= '0;
                        res_sr  <= '0;
                    end
                end
                S_RUN: begin
                    a_sr    <= a_sr >> 4;
                    b_sr    <= b_sr >> 4;
                    res_sr  <= res_nxt;
                    carry_q <= cell_c;
                    cnt     <= cnt + CW'(1);
                    // Bad operands still take the full digit count; only the outputs are squashed.
                    if (last_digit) begin
                        result_q <= err_q ? '0 : res_nxt;
                        cout_q   <= err_q ? 1'b0 : cell_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign err    = err_q;

endmodule
